// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter and its round-robin picker.
package mem_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } arbState_t;

    // Index width for a requester count, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NCORES = 2,
    localparam int PW = idxWidth(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic              any,
    output logic [PW-1:0]     winner
);

    logic [2*NCORES-1:0] reqDbl;
    logic [NCORES-1:0]   reqRot;

    // Rotating a doubled copy puts index ptr at bit 0 without variable bit-selects.
    assign reqDbl = {req, req};
    assign reqRot = NCORES'(reqDbl >> ptr);

    always_comb begin
        any    = 1'b0;
        winner = '0;
        for (int k = NCORES - 1; k >= 0; k--) begin
            if (reqRot[k]) begin
                any    = 1'b1;
                winner = PW'((int'(ptr) + k) % NCORES);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among the cores' M stages.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NCORES = 2,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    localparam int PW    = idxWidth(NCORES)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NCORES-1:0]    req,
    input  logic [NCORES-1:0]    we,
    input  logic [NCORES*AW-1:0] addr,
    input  logic [NCORES*DW-1:0] wdata,
    output logic [NCORES-1:0]    stall,
    output logic [NCORES-1:0]    done,
    output logic [DW-1:0]        rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 mem_ready
);

    arbState_t       state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   owner;
    logic            pickAny;
    logic [PW-1:0]   pickIdx;
    logic [AW-1:0]   addrArr  [NCORES];
    logic [DW-1:0]   wdataArr [NCORES];

    for (genvar i = 0; i < NCORES; i++) begin : g_unpack
        assign addrArr[i]  = addr[i*AW +: AW];
        assign wdataArr[i] = wdata[i*DW +: DW];
    end

    rr_pick #(.NCORES(NCORES)) uPick (
        .req    (req),
        .ptr    (ptr),
        .any    (pickAny),
        .winner (pickIdx)
    );

    assign stall = req & ~done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            owner     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            done      <= '0;
        end else begin
            done <= '0;
            case (state)
                ST_BUSY: begin
                    // A granted access always completes, even if its core has flushed.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            rdata <= mem_rdata;
                        end
                        done  <= NCORES'(1) << owner;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    ptr   <= (owner == PW'(NCORES - 1)) ? '0 : owner + 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    if (pickAny) begin
                        owner     <= pickIdx;
                        mem_req   <= 1'b1;
                        mem_we    <= we[pickIdx];
                        mem_addr  <= addrArr[pickIdx];
                        mem_wdata <= wdataArr[pickIdx];
                        state     <= ST_BUSY;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: latency, wait states, contention, fairness, flush, reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  stall;
    logic [1:0]  done;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NCORES(2), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] expDone;
        int donePulses;

        reset_n   = 1'b0;
        req       = 2'b01;
        we        = 2'b00;
        addr      = '0;
        wdata     = '0;
        mem_rdata = '0;
        mem_ready = 1'b1;

        // reset state; stall tracks req while held in reset
        mid();
        check("rst_stall", 32'(stall), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_mem_req", 32'(mem_req), 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        req = 2'b00;
        nextCycle();
        reset_n = 1'b1;
        nextCycle();

        // single load, zero wait states
        req = 2'b01; we = 2'b00; addr[31:0] = 32'h40; mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1;
        mid();
        check("ld_c0_stall", 32'(stall), 32'h1);
        check("ld_c0_mem_req", 32'(mem_req), 32'h0);
        nextCycle();
        mid();
        check("ld_c1_mem_req", 32'(mem_req), 32'h1);
        check("ld_c1_mem_addr", mem_addr, 32'h40);
        check("ld_c1_mem_we", 32'(mem_we), 32'h0);
        check("ld_c1_stall", 32'(stall), 32'h1);
        check("ld_c1_done", 32'(done), 32'h0);
        nextCycle();
        mid();
        check("ld_c2_done", 32'(done), 32'h1);
        check("ld_c2_rdata", rdata, 32'hDEADBEEF);
        check("ld_c2_stall", 32'(stall), 32'h0);
        nextCycle();
        req = 2'b00;
        mid();
        check("ld_c3_done", 32'(done), 32'h0);
        nextCycle();

        // store from core1 with three wait states; rdata must not move
        req = 2'b10; we = 2'b10; addr[63:32] = 32'h80; wdata[63:32] = 32'h1234;
        mem_ready = 1'b0; mem_rdata = 32'hCAFEF00D;
        mid();
        nextCycle();
        for (int c = 1; c <= 3; c++) begin
            mid();
            check("st_wait_mem_req", 32'(mem_req), 32'h1);
            check("st_wait_mem_we", 32'(mem_we), 32'h1);
            check("st_wait_mem_wdata", mem_wdata, 32'h1234);
            check("st_wait_done", 32'(done), 32'h0);
            nextCycle();
        end
        mem_ready = 1'b1;
        mid();
        check("st_c4_mem_req", 32'(mem_req), 32'h1);
        check("st_c4_mem_addr", mem_addr, 32'h80);
        nextCycle();
        mid();
        check("st_c5_done", 32'(done), 32'h2);
        check("st_c5_rdata", rdata, 32'hDEADBEEF);
        check("st_c5_mem_req", 32'(mem_req), 32'h0);
        nextCycle();
        req = 2'b00; we = 2'b00;
        mid();
        nextCycle();

        // contention from ptr=0: core0 first, core1 waits
        req = 2'b11; addr = {32'h200, 32'h100}; mem_rdata = 32'h11111111; mem_ready = 1'b1;
        mid();
        check("ct_c0_stall", 32'(stall), 32'h3);
        nextCycle();
        mid();
        check("ct_c1_mem_addr", mem_addr, 32'h100);
        nextCycle();
        mid();
        check("ct_c2_done", 32'(done), 32'h1);
        check("ct_c2_rdata", rdata, 32'h11111111);
        check("ct_c2_stall", 32'(stall), 32'h2);
        nextCycle();
        req = 2'b10;
        mid();
        check("ct_c3_stall", 32'(stall), 32'h2);
        check("ct_c3_mem_req", 32'(mem_req), 32'h0);
        nextCycle();
        mem_rdata = 32'h22222222;
        mid();
        check("ct_c4_mem_addr", mem_addr, 32'h200);
        check("ct_c4_stall", 32'(stall), 32'h2);
        nextCycle();
        mid();
        check("ct_c5_done", 32'(done), 32'h2);
        check("ct_c5_rdata", rdata, 32'h22222222);
        check("ct_c5_stall", 32'(stall), 32'h0);
        nextCycle();
        req = 2'b00;
        mid();
        nextCycle();

        // fairness: continuous requests alternate 0,1,0,1 every three cycles
        req = 2'b11; mem_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            expDone = (c % 3 != 2) ? 2'b00 : (((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
            mid();
            check("fair_done", 32'(done), 32'(expDone));
            nextCycle();
        end
        req = 2'b00;
        mid();
        nextCycle();

        // flush: core0 drops req while its access waits
        req = 2'b01; we = 2'b00; addr[31:0] = 32'h300; mem_ready = 1'b0;
        mid();
        nextCycle();
        req = 2'b00;
        mid();
        check("fl_c1_mem_req", 32'(mem_req), 32'h1);
        check("fl_c1_stall", 32'(stall), 32'h0);
        nextCycle();
        mem_ready = 1'b1;
        donePulses = 0;
        for (int c = 2; c <= 5; c++) begin
            mid();
            if (done == 2'b01) donePulses++;
            if (c == 3) check("fl_c3_done", 32'(done), 32'h1);
            nextCycle();
        end
        check("fl_pulse_count", 32'(donePulses), 32'h1);

        // reset asserted while an access waits in BUSY
        req = 2'b10; we = 2'b00; addr[63:32] = 32'h400; mem_ready = 1'b0; mem_rdata = 32'h33333333;
        mid();
        nextCycle();
        mid();
        check("rb_c1_mem_req", 32'(mem_req), 32'h1);
        check("rb_c1_mem_addr", mem_addr, 32'h400);
        nextCycle();
        #2;
        reset_n = 1'b0;
        #1;
        check("rb_async_mem_req", 32'(mem_req), 32'h0);
        check("rb_async_mem_addr", mem_addr, 32'h0);
        check("rb_async_rdata", rdata, 32'h0);
        check("rb_async_stall", 32'(stall), 32'h2);
        nextCycle();
        reset_n = 1'b1;
        req = 2'b00;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mid();
            check("rb_post_done", 32'(done), 32'h0);
            check("rb_post_mem_req", 32'(mem_req), 32'h0);
            nextCycle();
        end
        // ptr back at 0: core0 wins a simultaneous request
        req = 2'b11; addr = {32'h600, 32'h500}; mem_rdata = 32'h44444444;
        mid();
        nextCycle();
        mid();
        check("rb_ptr_mem_addr", mem_addr, 32'h500);
        nextCycle();
        mid();
        check("rb_ptr_done", 32'(done), 32'h1);
        check("rb_ptr_rdata", rdata, 32'h44444444);
        nextCycle();
        req = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
